// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencing states, forwarding selects and
// the idle encoding of the ID/EX memory-control field.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   // Value the ID/EX MEM control field takes when a bubble is loaded:
   // no read, no write.
   localparam logic [1:0] IDEX_MEM_IDLE = 2'b00;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX-stage source register. The youngest
// producer (MEM) wins over the older one (WB); register 0 is never forwarded.
module fwd_unit
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] ex_rs_i,
   input  logic [REG_W-1:0] mem_wreg_i,
   input  logic             mem_regwrite_i,
   input  logic [REG_W-1:0] wb_wreg_i,
   input  logic             wb_regwrite_i,
   output logic [1:0]       fwd_sel_o
);

   // Pick the nearest in-flight producer of ex_rs_i, else the register file.
   always_comb begin
      fwd_sel_o = FWD_RF;
      if (mem_regwrite_i && (mem_wreg_i != '0) && (mem_wreg_i == ex_rs_i)) begin
         fwd_sel_o = FWD_MEM;
      end else if (wb_regwrite_i && (wb_wreg_i != '0) && (wb_wreg_i == ex_rs_i)) begin
         fwd_sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the five-stage pipeline: load-use stalls,
// branch flushes, data-memory waits with timeout, and host halt/drain.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = 4,
   parameter int MEM_TIMEOUT  = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] ex_rs1,
   input  logic [REG_W-1:0] ex_rs2,
   input  logic [REG_W-1:0] ex_wreg,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic [REG_W-1:0] mem_wreg,
   input  logic             mem_regwrite,
   input  logic [REG_W-1:0] wb_wreg,
   input  logic             wb_regwrite,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [15:0]      flush_cnt
);

   localparam int TOUT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [TOUT_W-1:0]  TOUT_MAX   = TOUT_W'(MEM_TIMEOUT);
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

   state_e               state_q, state_d;
   state_e               ret_q, ret_d;
   logic [DRAIN_W-1:0]   drainCnt_q, drainCnt_d;
   logic [TOUT_W-1:0]    toutCnt_q, toutCnt_d;
   logic                 timeoutErr_q, timeoutErr_d;
   logic [CNT_W-1:0]     stallCnt_q, stallCnt_d;
   logic [15:0]          flushCnt_q, flushCnt_d;

   logic                 luh;
   logic                 freeze;
   logic                 drainMode;
   logic                 branchFlush;
   logic [1:0]           fwdA, fwdB;

   // ex_regwrite is implied by ex_memread for a load, so only the load flag
   // matters for the stall decision.
   logic                 unusedRegwrite;
   assign unusedRegwrite = ex_regwrite;

   assign luh = ex_memread && (ex_wreg != '0) &&
                ((id_rs1_used && (id_rs1 == ex_wreg)) ||
                 (id_rs2_used && (id_rs2 == ex_wreg)));

   // A pending access in MEM freezes the whole pipe, whether it is running
   // normally or still draining toward a halt.
   assign freeze = ((state_q == MEM_WAIT) && !dmem_ready) ||
                   (((state_q == RUN) || (state_q == DRAIN)) && dmem_req && !dmem_ready);

   // The ready cycle of a wait that interrupted a drain keeps inserting bubbles.
   assign drainMode = (state_q == DRAIN) || ((state_q == MEM_WAIT) && (ret_q == DRAIN));

   fwd_unit #(.REG_W(REG_W)) u_fwdA (
      .ex_rs_i        (ex_rs1),
      .mem_wreg_i     (mem_wreg),
      .mem_regwrite_i (mem_regwrite),
      .wb_wreg_i      (wb_wreg),
      .wb_regwrite_i  (wb_regwrite),
      .fwd_sel_o      (fwdA)
   );

   fwd_unit #(.REG_W(REG_W)) u_fwdB (
      .ex_rs_i        (ex_rs2),
      .mem_wreg_i     (mem_wreg),
      .mem_regwrite_i (mem_regwrite),
      .wb_wreg_i      (wb_wreg),
      .wb_regwrite_i  (wb_regwrite),
      .fwd_sel_o      (fwdB)
   );

   // Forwarding is meaningless while the pipe is held or in reset.
   assign fwd_a = (reset || (state_q == HALTED)) ? FWD_RF : fwdA;
   assign fwd_b = (reset || (state_q == HALTED)) ? FWD_RF : fwdB;

   // Pipeline register controls, priority freeze > drain > branch > load-use.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      halted      = 1'b0;
      branchFlush = 1'b0;
      if (reset) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (state_q == HALTED) begin
         halted = halt_req;
      end else if (freeze) begin
         pc_en = 1'b0;
      end else if (drainMode) begin
         ifid_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         branchFlush = 1'b1;
      end else if (luh) begin
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
      end
   end

   // Next state, drain/timeout counters and the statistics counters.
   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      drainCnt_d = drainCnt_q;
      toutCnt_d  = toutCnt_q;
      case (state_q)
         RUN: begin
            if (freeze) begin
               state_d   = MEM_WAIT;
               ret_d     = RUN;
               toutCnt_d = TOUT_W'(1);
            end else if (halt_req && !ex_branch_taken) begin
               state_d    = DRAIN;
               drainCnt_d = DRAIN_INIT;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = ret_q;
            end else if (toutCnt_q != TOUT_MAX) begin
               toutCnt_d = toutCnt_q + TOUT_W'(1);
            end
         end
         DRAIN: begin
            if (freeze) begin
               state_d   = MEM_WAIT;
               ret_d     = DRAIN;
               toutCnt_d = TOUT_W'(1);
            end else if (drainCnt_q == '0) begin
               state_d = HALTED;
            end else begin
               drainCnt_d = drainCnt_q - DRAIN_W'(1);
            end
         end
         HALTED: begin
            if (!halt_req) begin
               state_d = RUN;
            end
         end
      endcase

      timeoutErr_d = timeoutErr_q || ((state_d == MEM_WAIT) && (toutCnt_d == TOUT_MAX));

      stallCnt_d = stallCnt_q;
      if (((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_en && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + CNT_W'(1);
      end

      flushCnt_d = flushCnt_q;
      if (branchFlush && !(&flushCnt_q)) begin
         flushCnt_d = flushCnt_q + 16'd1;
      end
   end

   // State and counter registers; reset aborts any wait or drain at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RUN;
         ret_q        <= RUN;
         drainCnt_q   <= '0;
         toutCnt_q    <= '0;
         timeoutErr_q <= 1'b0;
         stallCnt_q   <= '0;
         flushCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         ret_q        <= ret_d;
         drainCnt_q   <= drainCnt_d;
         toutCnt_q    <= toutCnt_d;
         timeoutErr_q <= timeoutErr_d;
         stallCnt_q   <= stallCnt_d;
         flushCnt_q   <= flushCnt_d;
      end
   end

   assign timeout_err = timeoutErr_q;
   assign stall_cnt   = stallCnt_q;
   assign flush_cnt   = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, each cycle's expected outputs produced by a reference model.
module tb_pipeline_hazard_ctrl;

   localparam int TB_REG_W   = 5;
   localparam int TB_DRAIN   = 4;
   localparam int TB_TIMEOUT = 8;
   localparam int TB_CNT_W   = 8;
   localparam int STALL_MAX  = (1 << TB_CNT_W) - 1;
   localparam int FLUSH_MAX  = 65535;

   logic clk;
   logic reset;
   logic [TB_REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wreg, mem_wreg, wb_wreg;
   logic id_rs1_used, id_rs2_used, ex_regwrite, ex_memread, ex_branch_taken;
   logic mem_regwrite, wb_regwrite, dmem_req, dmem_ready, halt_req;
   logic pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble;
   logic [1:0] fwd_a, fwd_b;
   logic halted, timeout_err;
   logic [TB_CNT_W-1:0] stall_cnt;
   logic [15:0] flush_cnt;

   typedef struct packed {
      logic [5:0]  ctrl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        halted;
      logic        err;
      logic [7:0]  stall;
      logic [15:0] flushCnt;
   } expect_t;

   expect_t expQ[$];

   int nCompared;
   int nMismatched;

   bit mWaiting, mDraining, mHalted, mErr;
   int mDrainLeft, mWaitCycles, mStall, mFlush;

   pipeline_hazard_ctrl #(
      .REG_W(TB_REG_W), .DRAIN_CYCLES(TB_DRAIN), .MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
      .mem_wreg(mem_wreg), .mem_regwrite(mem_regwrite),
      .wb_wreg(wb_wreg), .wb_regwrite(wb_regwrite),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .timeout_err(timeout_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Free-running pipeline clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwdExpect(input logic [4:0] rs, input logic [4:0] mw, input logic mwr,
                                            input logic [4:0] ww, input logic wwr);
      if (mwr && mw != 0 && mw == rs) return 2'b10;
      if (wwr && ww != 0 && ww == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_wreg, mem_wreg, wb_wreg} = '0;
      {id_rs1_used, id_rs2_used, ex_regwrite, ex_memread, ex_branch_taken} = '0;
      {mem_regwrite, wb_regwrite, dmem_req, halt_req} = '0;
      dmem_ready = 1'b1;
   endtask

   // Commits the inputs driven for this cycle: queues what the pipeline
   // should show now, then advances the model past the coming clock edge.
   task automatic applyStimulus();
      expect_t e;
      logic loadUse, memStall;
      e = '0;
      if (reset) begin
         mWaiting = 0; mDraining = 0; mHalted = 0; mErr = 0;
         mDrainLeft = 0; mWaitCycles = 0; mStall = 0; mFlush = 0;
         e.ctrl = 6'b000011;
      end else begin
         loadUse = ex_memread && ex_wreg != 0 &&
                   ((id_rs1_used && id_rs1 == ex_wreg) || (id_rs2_used && id_rs2 == ex_wreg));
         memStall = !dmem_ready && (mWaiting || (dmem_req && !mHalted));
         e.fa = fwdExpect(ex_rs1, mem_wreg, mem_regwrite, wb_wreg, wb_regwrite);
         e.fb = fwdExpect(ex_rs2, mem_wreg, mem_regwrite, wb_wreg, wb_regwrite);
         if (mHalted) begin
            e.ctrl = 6'b000000; e.halted = halt_req; e.fa = 2'b00; e.fb = 2'b00;
         end else if (memStall) e.ctrl = 6'b000000;
         else if (mDraining)    e.ctrl = 6'b011111;
         else if (ex_branch_taken) e.ctrl = 6'b111111;
         else if (loadUse)      e.ctrl = 6'b001101;
         else                   e.ctrl = 6'b111100;
      end
      e.err = mErr;
      e.stall = 8'(mStall);
      e.flushCnt = 16'(mFlush);
      expQ.push_back(e);
      if (reset) return;

      if (!mHalted && (mWaiting || !mDraining) && !e.ctrl[5] && mStall < STALL_MAX) mStall++;
      if (!mHalted && !memStall && !mDraining && ex_branch_taken && mFlush < FLUSH_MAX) mFlush++;

      if (mHalted) begin
         if (!halt_req) mHalted = 0;
      end else if (mWaiting) begin
         if (dmem_ready) mWaiting = 0;
         else begin
            if (mWaitCycles < TB_TIMEOUT) mWaitCycles++;
            if (mWaitCycles == TB_TIMEOUT) mErr = 1;
         end
      end else if (memStall) begin
         mWaiting = 1; mWaitCycles = 1;
         if (TB_TIMEOUT == 1) mErr = 1;
      end else if (mDraining) begin
         if (mDrainLeft == 0) begin mDraining = 0; mHalted = 1; end
         else mDrainLeft--;
      end else if (halt_req && !ex_branch_taken) begin
         mDraining = 1; mDrainLeft = TB_DRAIN - 1;
      end
   endtask

   // Monitor: mid-cycle, compare the DUT against the oldest queued expectation.
   always @(negedge clk) begin
      expect_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("ctrl", {26'd0, pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble}, {26'd0, e.ctrl});
         checkOutput("fwd", {28'd0, fwd_a, fwd_b}, {28'd0, e.fa, e.fb});
         checkOutput("status", {30'd0, halted, timeout_err}, {30'd0, e.halted, e.err});
         checkOutput("stall_cnt", {24'd0, stall_cnt}, {24'd0, e.stall});
         checkOutput("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.flushCnt});
      end
   end

   // Directed scenarios, random traffic, then counter saturation.
   initial begin
      bit haltLvl;
      nCompared = 0;
      nMismatched = 0;
      idleInputs();
      reset = 1'b1;

      nextCycle(); applyStimulus();
      #1 checkOutput("reset pc_en", pc_en, 0);
      checkOutput("reset flush/bubble", {ifid_flush, idex_bubble}, 2'b11);
      checkOutput("reset stall_cnt", stall_cnt, 0);

      nextCycle(); reset = 1'b0; applyStimulus();

      nextCycle(); ex_memread = 1; ex_wreg = 5; id_rs1 = 5; id_rs1_used = 1; applyStimulus();
      #1 checkOutput("luh pc/ifid/bubble", {pc_en, ifid_en, idex_bubble, exmem_en}, 4'b0011);
      nextCycle(); idleInputs(); applyStimulus();
      #1 checkOutput("luh stall_cnt", stall_cnt, 1);

      nextCycle(); ex_memread = 1; ex_wreg = 5; id_rs1 = 5; id_rs1_used = 1; ex_branch_taken = 1;
      applyStimulus();
      #1 checkOutput("br+luh flush/bubble/pc", {ifid_flush, idex_bubble, pc_en}, 3'b111);
      nextCycle(); idleInputs(); applyStimulus();
      #1 checkOutput("br flush_cnt", flush_cnt, 1);
      checkOutput("br stall_cnt", stall_cnt, 1);

      nextCycle(); mem_wreg = 3; wb_wreg = 3; ex_rs1 = 3; mem_regwrite = 1; wb_regwrite = 1;
      applyStimulus();
      #1 checkOutput("fwd mem wins", fwd_a, 2'b10);
      nextCycle(); mem_wreg = 0; wb_wreg = 0; ex_rs1 = 0; applyStimulus();
      #1 checkOutput("fwd r0", fwd_a, 2'b00);

      idleInputs();
      for (int k = 0; k < 3; k++) begin
         nextCycle(); dmem_req = 1; dmem_ready = 0; applyStimulus();
         #1 checkOutput("memwait enables", {pc_en, ifid_en, exmem_en, memwb_en}, 4'b0000);
      end
      nextCycle(); dmem_ready = 1; applyStimulus();
      #1 checkOutput("memwait release", {pc_en, ifid_en, exmem_en, memwb_en}, 4'b1111);
      nextCycle(); idleInputs(); applyStimulus();
      #1 checkOutput("memwait stall_cnt", stall_cnt, 4);

      for (int k = 1; k <= 10; k++) begin
         nextCycle(); dmem_req = 1; dmem_ready = 0; applyStimulus();
         if (k == 8) #1 checkOutput("timeout not yet", timeout_err, 0);
         if (k == 9) #1 checkOutput("timeout raised", timeout_err, 1);
      end
      for (int k = 0; k < 3; k++) begin
         nextCycle(); idleInputs(); applyStimulus();
      end
      #1 checkOutput("timeout sticky", timeout_err, 1);

      nextCycle(); halt_req = 1; applyStimulus();
      #1 checkOutput("halt entry run", pc_en, 1);
      for (int k = 0; k < TB_DRAIN; k++) begin
         nextCycle(); applyStimulus();
         #1 checkOutput("drain bubbles", {pc_en, ifid_en, ifid_flush, idex_bubble, halted}, 5'b01110);
      end
      nextCycle(); applyStimulus();
      #1 checkOutput("halted", {halted, pc_en}, 2'b10);
      nextCycle(); halt_req = 0; applyStimulus();
      #1 checkOutput("halted drop", halted, 0);
      nextCycle(); applyStimulus();
      #1 checkOutput("run after halt", pc_en, 1);

      nextCycle(); halt_req = 1; applyStimulus();
      nextCycle(); applyStimulus();
      nextCycle(); reset = 1; applyStimulus();
      #1 checkOutput("reset in drain counters", {timeout_err, stall_cnt, flush_cnt}, 25'd0);
      nextCycle(); reset = 0; halt_req = 0; applyStimulus();
      #1 checkOutput("run after reset", pc_en, 1);

      haltLvl = 0;
      for (int i = 0; i < 3000; i++) begin
         nextCycle();
         if ($urandom_range(0, 29) == 0) haltLvl = ~haltLvl;
         reset           = ($urandom_range(0, 199) == 0);
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         ex_rs1          = 5'($urandom_range(0, 3));
         ex_rs2          = 5'($urandom_range(0, 3));
         ex_wreg         = 5'($urandom_range(0, 3));
         mem_wreg        = 5'($urandom_range(0, 3));
         wb_wreg         = 5'($urandom_range(0, 3));
         id_rs1_used     = 1'($urandom);
         id_rs2_used     = 1'($urandom);
         ex_regwrite     = 1'($urandom);
         ex_memread      = ($urandom_range(0, 2) == 0);
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         mem_regwrite    = 1'($urandom);
         wb_regwrite     = 1'($urandom);
         dmem_req        = ($urandom_range(0, 3) == 0);
         dmem_ready      = 1'($urandom);
         halt_req        = haltLvl;
         applyStimulus();
      end

      nextCycle(); idleInputs(); reset = 0; applyStimulus();
      nextCycle(); applyStimulus();
      for (int k = 0; k < 300; k++) begin
         nextCycle(); dmem_req = 1; dmem_ready = 0; applyStimulus();
      end
      nextCycle(); idleInputs(); applyStimulus();
      #1 checkOutput("stall_cnt saturated", stall_cnt, STALL_MAX);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
